// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
package btb_pkg;

    // Widest tag any legal geometry can need (SETS >= 2 leaves at most 29 tag bits).
    localparam int TAG_W_MAX = 29;

    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           ctr;
    } btb_entry_t;

    // 2-bit saturating direction counter step.
    function automatic logic [1:0] sat_ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_STRONG_T) nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_STRONG_NT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Allocation victim choice: lowest invalid way first, otherwise the round-robin way.
module btb_victim_sel #(
    parameter int WAYS     = 2,
    parameter int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [WAYS-1:0]     valid_vec,
    input  logic [WAY_BITS-1:0] rr_ptr,
    output logic [WAY_BITS-1:0] victim_way,
    output logic [WAY_BITS-1:0] alloc_advance
);

    logic w_found;

    // Scan upward so the lowest-numbered invalid way is taken.
    always_comb begin
        victim_way = rr_ptr;
        w_found    = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found && !valid_vec[w]) begin
                victim_way = WAY_BITS'(w);
                w_found    = 1'b1;
            end
        end
    end

    // Pointer value after an allocation; WAYS is a power of two so the add wraps mod WAYS.
    assign alloc_advance = (WAYS == 1) ? '0 : rr_ptr + WAY_BITS'(1);

endmodule

// File: rtl/btb_set_assoc.sv
// N-way set-associative BTB: combinational lookup on the fetch PC,
// clocked updates from branch resolution, per-set round-robin replacement.
module btb_set_assoc
    import btb_pkg::*;
#(
    parameter int         SETS     = 256,
    parameter int         WAYS     = 2,
    parameter int         IDX_BITS = $clog2(SETS),
    parameter int         TAG_BITS = 30 - IDX_BITS,
    parameter int         WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1,
    parameter logic [1:0] CTR_INIT = 2'b10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] lookup_pc,
    output logic        btb_hit,
    output logic        predicted_taken,
    output logic [31:0] predicted_target,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target
);

    // Valid/counter/pointer state is reset; tag and target are plain data flops.
    logic [WAYS-1:0]     r_valid  [SETS];
    logic [1:0]          r_ctr    [SETS][WAYS];
    logic [TAG_BITS-1:0] r_tag    [SETS][WAYS];
    logic [31:0]         r_target [SETS][WAYS];
    logic [WAY_BITS-1:0] r_rr_ptr [SETS];

    logic [IDX_BITS-1:0] w_lk_idx;
    logic [TAG_BITS-1:0] w_lk_tag;
    logic [IDX_BITS-1:0] w_up_idx;
    logic [TAG_BITS-1:0] w_up_tag;

    logic                w_lk_found;
    btb_entry_t          w_hit_entry;

    logic                w_up_hit;
    logic [WAY_BITS-1:0] w_up_way;
    logic [WAY_BITS-1:0] w_victim_way;
    logic [WAY_BITS-1:0] w_rr_next;

    logic                w_unused;

    assign w_lk_idx = lookup_pc[IDX_BITS+1:2];
    assign w_lk_tag = lookup_pc[31:IDX_BITS+2];
    assign w_up_idx = update_pc[IDX_BITS+1:2];
    assign w_up_tag = update_pc[31:IDX_BITS+2];

    // Lookup: lowest-numbered matching way wins; a miss yields an all-zero entry.
    always_comb begin
        w_hit_entry = '0;
        w_lk_found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_lk_found && r_valid[w_lk_idx][w] && (r_tag[w_lk_idx][w] == w_lk_tag)) begin
                w_lk_found         = 1'b1;
                w_hit_entry.valid  = 1'b1;
                w_hit_entry.tag    = TAG_W_MAX'(r_tag[w_lk_idx][w]);
                w_hit_entry.target = r_target[w_lk_idx][w];
                w_hit_entry.ctr    = r_ctr[w_lk_idx][w];
            end
        end
    end

    assign btb_hit          = w_hit_entry.valid;
    assign predicted_taken  = w_hit_entry.valid & w_hit_entry.ctr[1];
    assign predicted_target = w_hit_entry.target;

    // Update-side tag match in the resolved PC's set, lowest way first.
    always_comb begin
        w_up_hit = 1'b0;
        w_up_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_up_hit && r_valid[w_up_idx][w] && (r_tag[w_up_idx][w] == w_up_tag)) begin
                w_up_hit = 1'b1;
                w_up_way = WAY_BITS'(w);
            end
        end
    end

    btb_victim_sel #(
        .WAYS     (WAYS),
        .WAY_BITS (WAY_BITS)
    ) u_victim_sel (
        .valid_vec     (r_valid[w_up_idx]),
        .rr_ptr        (r_rr_ptr[w_up_idx]),
        .victim_way    (w_victim_way),
        .alloc_advance (w_rr_next)
    );

    // Control state: flush beats update; hits train the counter, taken misses allocate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s]  <= '0;
                r_rr_ptr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_ctr[s][w] <= CTR_STRONG_NT;
                end
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s]  <= '0;
                r_rr_ptr[s] <= '0;
            end
        end else if (update_en) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx][w_up_way] <= sat_ctr_update(r_ctr[w_up_idx][w_up_way], update_taken);
            end else if (update_taken) begin
                r_valid[w_up_idx][w_victim_way] <= 1'b1;
                r_ctr[w_up_idx][w_victim_way]   <= CTR_INIT;
                r_rr_ptr[w_up_idx]              <= w_rr_next;
            end
        end
    end

    // Payload: target refreshes only on taken hits; tag and target written on allocation.
    always_ff @(posedge clk) begin
        if (!flush && update_en && update_taken) begin
            if (w_up_hit) begin
                r_target[w_up_idx][w_up_way] <= update_target;
            end else begin
                r_tag[w_up_idx][w_victim_way]    <= w_up_tag;
                r_target[w_up_idx][w_victim_way] <= update_target;
            end
        end
    end

    // Byte-offset bits and the unused parts of the hit entry are intentionally ignored.
    assign w_unused = ^{lookup_pc[1:0], update_pc[1:0], w_hit_entry.tag, w_hit_entry.ctr[0]};

endmodule

// File: tb/tb_btb_set_assoc.sv
// Directed bench for btb_set_assoc (SETS=4, WAYS=2): index=pc[3:2], tag=pc[31:4].
module tb_btb_set_assoc;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] lookup_pc;
    logic        btb_hit;
    logic        predicted_taken;
    logic [31:0] predicted_target;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t sb[$];

    btb_set_assoc #(
        .SETS (4),
        .WAYS (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .lookup_pc        (lookup_pc),
        .btb_hit          (btb_hit),
        .predicted_taken  (predicted_taken),
        .predicted_target (predicted_target),
        .update_en        (update_en),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .update_target    (update_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    // Push the expectation, drive the lookup, then pop and compare once it settles.
    task automatic check_lookup(input string name, input logic [31:0] pc,
                                input logic e_hit, input logic e_tk, input logic [31:0] e_tgt);
        exp_t e;
        sb.push_back('{name, e_hit, e_tk, e_tgt});
        lookup_pc = pc;
        #1;
        e = sb.pop_front();
        chk({e.name, ".hit"},    {31'd0, btb_hit},         {31'd0, e.hit});
        chk({e.name, ".taken"},  {31'd0, predicted_taken}, {31'd0, e.taken});
        chk({e.name, ".target"}, predicted_target,         e.target);
    endtask

    task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        update_en     = 1'b1;
        update_pc     = pc;
        update_taken  = tk;
        update_target = tgt;
        @(posedge clk);
        #1;
        update_en = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        update_en     = 1'b0;
        update_pc     = '0;
        update_taken  = 1'b0;
        update_target = '0;
        lookup_pc     = 32'h10;
        #2;
        check_lookup("in_reset", 32'h10, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check_lookup("reset_miss", 32'h10, 1'b0, 1'b0, 32'h0);

        // Allocate, weakly taken
        do_update(32'h10, 1'b1, 32'h80);
        check_lookup("alloc", 32'h10, 1'b1, 1'b1, 32'h80);

        // Counter down with saturation; not-taken never touches target
        do_update(32'h10, 1'b0, 32'hDEAD);
        check_lookup("ctr01", 32'h10, 1'b1, 1'b0, 32'h80);
        do_update(32'h10, 1'b0, 32'hDEAD);
        check_lookup("ctr00", 32'h10, 1'b1, 1'b0, 32'h80);
        do_update(32'h10, 1'b0, 32'hDEAD);
        check_lookup("ctr00_sat", 32'h10, 1'b1, 1'b0, 32'h80);
        // Counter up; taken hits refresh target
        do_update(32'h10, 1'b1, 32'h84);
        check_lookup("ctr01_up", 32'h10, 1'b1, 1'b0, 32'h84);
        do_update(32'h10, 1'b1, 32'h88);
        check_lookup("ctr10_up", 32'h10, 1'b1, 1'b1, 32'h88);
        do_update(32'h10, 1'b1, 32'h8C);
        check_lookup("ctr11", 32'h10, 1'b1, 1'b1, 32'h8C);
        do_update(32'h10, 1'b1, 32'h8C);
        check_lookup("ctr11_sat", 32'h10, 1'b1, 1'b1, 32'h8C);
        do_update(32'h10, 1'b0, 32'h0);
        check_lookup("ctr10_dn", 32'h10, 1'b1, 1'b1, 32'h8C);
        do_update(32'h10, 1'b0, 32'h0);
        check_lookup("ctr01_dn", 32'h10, 1'b1, 1'b0, 32'h8C);

        // Flush alone clears valid and pointers
        do_flush();
        check_lookup("flush_miss", 32'h10, 1'b0, 1'b0, 32'h0);

        // Replacement in set 0
        do_update(32'h10, 1'b1, 32'h100);
        do_update(32'h50, 1'b1, 32'h150);
        check_lookup("fill_w0", 32'h10, 1'b1, 1'b1, 32'h100);
        check_lookup("fill_w1", 32'h50, 1'b1, 1'b1, 32'h150);
        do_update(32'h90, 1'b1, 32'h190);
        check_lookup("evict_10", 32'h10, 1'b0, 1'b0, 32'h0);
        check_lookup("keep_50", 32'h50, 1'b1, 1'b1, 32'h150);
        check_lookup("new_90", 32'h90, 1'b1, 1'b1, 32'h190);
        do_update(32'hD0, 1'b1, 32'h1D0);
        check_lookup("evict_50", 32'h50, 1'b0, 1'b0, 32'h0);
        check_lookup("keep_90", 32'h90, 1'b1, 1'b1, 32'h190);
        check_lookup("new_D0", 32'hD0, 1'b1, 1'b1, 32'h1D0);

        // Not-taken miss allocates nothing
        do_update(32'h24, 1'b0, 32'h224);
        check_lookup("nt_miss", 32'h24, 1'b0, 1'b0, 32'h0);
        check_lookup("nt_keep_90", 32'h90, 1'b1, 1'b1, 32'h190);
        check_lookup("nt_keep_D0", 32'hD0, 1'b1, 1'b1, 32'h1D0);

        // Same-cycle lookup sees pre-update contents
        update_en     = 1'b1;
        update_pc     = 32'h14;
        update_taken  = 1'b1;
        update_target = 32'h214;
        check_lookup("same_cyc", 32'h14, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        update_en = 1'b0;
        check_lookup("next_cyc", 32'h14, 1'b1, 1'b1, 32'h214);

        // Flush beats a simultaneous update
        update_en     = 1'b1;
        update_pc     = 32'h18;
        update_taken  = 1'b1;
        update_target = 32'h218;
        do_flush();
        update_en = 1'b0;
        check_lookup("flush_18", 32'h18, 1'b0, 1'b0, 32'h0);
        check_lookup("flush_14", 32'h14, 1'b0, 1'b0, 32'h0);
        check_lookup("flush_90", 32'h90, 1'b0, 1'b0, 32'h0);

        // Async reset drops hit mid-cycle
        do_update(32'h1C, 1'b1, 32'h31C);
        check_lookup("pre_rst", 32'h1C, 1'b1, 1'b1, 32'h31C);
        reset = 1'b1;
        check_lookup("async_rst", 32'h1C, 1'b0, 1'b0, 32'h0);

        // Update presented as reset deasserts is accepted
        @(posedge clk);
        #1;
        reset         = 1'b0;
        update_en     = 1'b1;
        update_pc     = 32'h1C;
        update_taken  = 1'b1;
        update_target = 32'h41C;
        check_lookup("rst_rel", 32'h1C, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        update_en = 1'b0;
        check_lookup("post_rst_upd", 32'h1C, 1'b1, 1'b1, 32'h41C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/btb_set_assoc.md
Name:
btb_set_assoc

Overview:
- Parametrised successor to the direct-mapped BTB: N-way set-associative branch target buffer with a 2-bit saturating direction counter per entry and per-set round-robin replacement.
- Sits in the fetch stage. Lookup is combinational on the fetch PC and returns hit, direction and target in the same cycle.
- Updates come from the execute-stage branch resolution and are written on the clock edge.

Parameters:
- SETS, 256: number of sets; power of 2, ≥2.
- WAYS, 2: associativity; power of 2, ≥1.
- IDX_BITS, $clog2(SETS): set index width (derived).
- TAG_BITS, 30-IDX_BITS: tag width (derived).
- WAY_BITS, (WAYS>1)?$clog2(WAYS):1: round-robin pointer width (derived).
- CTR_INIT, 2'b10: counter value written on allocation (weakly taken).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous invalidate of the whole table.
- lookup_pc  in  32  fetch PC.
- btb_hit  out  1  valid tag match in the indexed set.
- predicted_taken  out  1  btb_hit & counter[1] of the hit way.
- predicted_target  out  32  target of the hit way; 0 on miss.
- update_en  in  1  resolved branch/jump this cycle.
- update_pc  in  32  PC of the resolved instruction.
- update_taken  in  1  actual direction.
- update_target  in  32  actual target.

Behaviour:
- Address split: index = pc[IDX_BITS+1:2]; tag = pc[31:IDX_BITS+2]; pc[1:0] ignored.
- Entry fields: valid, tag[TAG_BITS], target[32], ctr[2]. Each set also holds rr_ptr[WAY_BITS].
- Lookup (combinational, 0-cycle latency):
  - A way hits when valid && tag==lookup tag.
  - If more than one way hits, the lowest-numbered way wins.
  - Miss: btb_hit=0, predicted_taken=0, predicted_target=0.
- Update, on posedge clk when update_en=1 and flush=0, using update_pc's set:
  - Tag hit: ctr increments on taken and decrements on not-taken, saturating at 2'b11 and 2'b00. target is overwritten only when update_taken=1. rr_ptr is unchanged.
  - Miss with update_taken=1: allocate. Victim is the lowest-numbered invalid way; if every way is valid, the victim is way rr_ptr. Write valid=1, tag, target=update_target, ctr=CTR_INIT. rr_ptr advances by 1 mod WAYS on every allocation.
  - Miss with update_taken=0: no change to the table.
- Same-cycle lookup and update to the same set: the lookup returns pre-update contents. No write-through bypass.
- flush=1: at the next posedge, every valid bit and every rr_ptr clears to 0. Takes priority over update_en in the same cycle. tag, target and ctr are not cleared.
- Reset (async, any time, including mid-update): all valid, ctr and rr_ptr clear to 0 immediately.
  - Outputs during and after reset: btb_hit=0, predicted_taken=0, predicted_target=0.
  - An update presented in the cycle reset deasserts is accepted normally.
- Storage is a flop array; no SRAM macro.

Decomposition:
- btb_pkg holds:
  - typedef btb_entry_t, a packed struct {valid, tag, target, ctr}, parameterised through the package localparams;
  - function sat_ctr_update(ctr, taken) returning the 2-bit result;
  - localparam CTR_STRONG_NT=2'b00 through CTR_STRONG_T=2'b11.
- One sub-module, btb_victim_sel: combinational. Inputs are the per-way valid vector and rr_ptr; outputs are victim_way and alloc_advance. Parameterised by WAYS.

Test Plan:
All scenarios use SETS=4, WAYS=2: index=pc[3:2], tag=pc[31:4].
1. Reset, then lookup 0x10 -> btb_hit=0, predicted_taken=0, predicted_target=0x0.
2. Update pc=0x10, taken, target=0x80; next cycle lookup 0x10 -> hit=1, taken=1, target=0x80, ctr=2'b10.
3. Counter: apply three not-taken updates to 0x10 -> ctr goes 01, then 00, then stays 00. Lookup gives hit=1, taken=0, target still 0x80. Then apply three taken updates -> ctr goes 01, 10, 11 and saturates.
4. Replacement: allocate taken 0x10 (way0, ptr->1), then 0x50 (way1, first invalid, ptr->0), then 0x90 (evicts way0, ptr->1) -> lookup 0x10 misses, 0x50 hits, 0x90 hits.
5. Not-taken miss: update pc=0x24, not taken -> lookup 0x24 misses and no other entry changes. In the same cycle as a taken update to 0x14, lookup 0x14 -> hit=0 that cycle and hit=1 the next cycle.
6. Flush and reset:
   - Assert flush together with update_en (pc=0x18, taken) -> all lookups miss the next cycle, including 0x18.
   - Assert reset mid-stream -> btb_hit drops to 0 without waiting for a clock edge.
